// File: rtl/spi_reg_bank_if.sv
// Pin-side SPI signals plus the register/status outputs of spi_reg_bank.
// master = host/board side, slave = the register bank itself.
interface spi_reg_bank_if #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8
);
    logic                         sclk;
    logic                         ncs;
    logic                         copi;
    logic                         cipo;
    logic                         cipo_oe;
    logic [NUM_REGS*DATA_W-1:0]   regs_flat;
    logic [NUM_REGS-1:0]          wr_strobe;
    logic                         frame_err;
    logic [7:0]                   err_count;

    modport master (
        output sclk, ncs, copi,
        input  cipo, cipo_oe, regs_flat, wr_strobe, frame_err, err_count
    );

    modport slave (
        input  sclk, ncs, copi,
        output cipo, cipo_oe, regs_flat, wr_strobe, frame_err, err_count
    );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 config register bank: {rw, addr, data} frames, read-back, length check, error counter.
// Register update lands SYNC_STAGES+2 clk after pin ncs rise; no backpressure, host paces via sclk.
module spi_reg_bank #(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    spi_reg_bank_if.slave  bus
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(ADDR_W);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    // One extra flop past the synchroniser so edges compare two settled samples.
    logic [SYNC_STAGES:0]   sclk_q;
    logic [SYNC_STAGES:0]   ncs_q;
    logic [SYNC_STAGES-1:0] copi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '1;
            ncs_q  <= '1;
            copi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-1:0], bus.sclk};
            ncs_q  <= {ncs_q[SYNC_STAGES-1:0], bus.ncs};
            copi_q <= {copi_q[SYNC_STAGES-2:0], bus.copi};
        end
    end

    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s, ncs_s;
    assign sclk_rise =  sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] &  sclk_q[SYNC_STAGES];
    assign ncs_rise  =  ncs_q[SYNC_STAGES-1]  & ~ncs_q[SYNC_STAGES];
    assign ncs_fall  = ~ncs_q[SYNC_STAGES-1]  &  ncs_q[SYNC_STAGES];
    assign copi_s    = copi_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_q[SYNC_STAGES-1];

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [FRAME_W-1:0]  shift_in;
    logic [DATA_W-1:0]   out_sh;
    logic                cipo_q;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] strobe_q;
    logic                err_q;
    logic [7:0]          err_cnt_q;

    logic [FRAME_W-1:0]  shift_nxt;
    logic                hdr_rw;
    logic [ADDR_W-1:0]   hdr_addr;
    logic                fr_rw;
    logic [ADDR_W-1:0]   fr_addr;
    logic [DATA_W-1:0]   fr_data;
    logic [DATA_W-1:0]   rd_word;
    logic [NUM_REGS-1:0] wr_sel;

    assign shift_nxt = {shift_in[FRAME_W-2:0], copi_s};
    assign hdr_rw    = shift_nxt[ADDR_W];
    assign hdr_addr  = shift_nxt[ADDR_W-1:0];
    assign fr_rw     = shift_in[FRAME_W-1];
    assign fr_addr   = shift_in[DATA_W +: ADDR_W];
    assign fr_data   = shift_in[DATA_W-1:0];

    // Unimplemented addresses decode to no register: reads give 0, writes select nothing.
    always_comb begin
        rd_word = '0;
        wr_sel  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_addr == ADDR_W'(i)) rd_word = regs[i];
            wr_sel[i] = (fr_addr == ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_in  <= '0;
            out_sh    <= '0;
            cipo_q    <= 1'b0;
            strobe_q  <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            strobe_q <= '0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state    <= SHIFT;
                        cnt      <= '0;
                        shift_in <= '0;
                        out_sh   <= '0;
                        cipo_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state  <= COMMIT;
                        out_sh <= '0;
                        cipo_q <= 1'b0;
                    end else if (sclk_rise) begin
                        shift_in <= shift_nxt;
                        if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_HDR && !hdr_rw) out_sh <= rd_word;
                    end else if (sclk_fall) begin
                        cipo_q <= out_sh[DATA_W-1];
                        out_sh <= {out_sh[DATA_W-2:0], 1'b0};
                    end
                end
                COMMIT: begin
                    if (cnt == CNT_FULL) begin
                        if (fr_rw) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (wr_sel[i]) begin
                                    regs[i]     <= fr_data;
                                    strobe_q[i] <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        err_q <= 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                    end
                    // A new frame may already have started during the commit cycle.
                    if (ncs_fall) begin
                        state    <= SHIFT;
                        cnt      <= '0;
                        shift_in <= '0;
                        out_sh   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [NUM_REGS*DATA_W-1:0] flat;
    always_comb begin
        flat = '0;
        for (int i = 0; i < NUM_REGS; i++) flat[i*DATA_W +: DATA_W] = regs[i];
    end

    assign bus.regs_flat = flat;
    assign bus.wr_strobe = strobe_q;
    assign bus.frame_err = err_q;
    assign bus.err_count = err_cnt_q;
    assign bus.cipo      = cipo_q;
    assign bus.cipo_oe   = ~ncs_s;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: host frames bit-banged on the pins, hand-computed expectations.
module tb_spi_reg_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_reg_bank_if #(.NUM_REGS(5), .DATA_W(8)) bus ();

    spi_reg_bank #(.NUM_REGS(5), .ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int strobe_cycles = 0;
    int err_cycles    = 0;

    always @(negedge clk) begin
        if (bus.wr_strobe != 5'b0) strobe_cycles++;
        if (bus.frame_err) err_cycles++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives nbits of frame MSB first with 6-clk sclk phases; captures cipo before each rise.
    task automatic spi_xfer(input logic [31:0] frame, input int nbits, input bit raise,
                            output logic [31:0] miso, output logic oe_mid);
        miso   = '0;
        oe_mid = 1'b0;
        bus.ncs = 1'b0;
        wait_clk(6);
        oe_mid = bus.cipo_oe;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.copi = frame[i];
            wait_clk(6);
            miso = {miso[30:0], bus.cipo};
            bus.sclk = 1'b1;
            wait_clk(6);
            bus.sclk = 1'b0;
        end
        bus.copi = 1'b0;
        wait_clk(6);
        if (raise) bus.ncs = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sclk = 1'b0;
        bus.ncs  = 1'b1;
        bus.copi = 1'b0;
        wait_clk(3);
        vectors++;
        if (bus.regs_flat !== 40'h0) begin miscompares++; $display("FAIL reset_regs: got %0h expected 0", bus.regs_flat); end
        vectors++;
        if ({bus.wr_strobe, bus.frame_err, bus.cipo, bus.cipo_oe} !== 9'h0) begin
            miscompares++; $display("FAIL reset_ctl: got %0h expected 0", {bus.wr_strobe, bus.frame_err, bus.cipo, bus.cipo_oe});
        end
        vectors++;
        if (bus.err_count !== 8'h0) begin miscompares++; $display("FAIL reset_errcnt: got %0h expected 0", bus.err_count); end
        rst = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_write();
        logic [31:0] m;
        logic oe;
        int s0, lat;
        s0 = strobe_cycles;
        spi_xfer(32'h84A5, 16, 1'b1, m, oe);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.wr_strobe != 5'b0) begin lat = c; break; end
        end
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL write_latency: got %0d clk expected 4", lat); end
        vectors++;
        if (bus.wr_strobe !== 5'b10000) begin miscompares++; $display("FAIL write_strobe: got %b expected 10000", bus.wr_strobe); end
        vectors++;
        if (bus.regs_flat !== 40'hA5_00_00_00_00) begin miscompares++; $display("FAIL write_regs: got %0h expected a500000000", bus.regs_flat); end
        vectors++;
        if (oe !== 1'b1) begin miscompares++; $display("FAIL write_oe_mid: got %b expected 1", oe); end
        wait_clk(1);
        vectors++;
        if (bus.wr_strobe !== 5'b0) begin miscompares++; $display("FAIL write_strobe_width: got %b expected 0", bus.wr_strobe); end
        wait_clk(5);
        vectors++;
        if (strobe_cycles - s0 !== 1) begin miscompares++; $display("FAIL write_strobe_count: got %0d expected 1", strobe_cycles - s0); end
        vectors++;
        if (bus.cipo_oe !== 1'b0) begin miscompares++; $display("FAIL write_oe_idle: got %b expected 0", bus.cipo_oe); end
    endtask

    task automatic test_read();
        logic [31:0] m;
        logic oe;
        int s0, e0;
        s0 = strobe_cycles;
        e0 = err_cycles;
        spi_xfer(32'h0400, 16, 1'b1, m, oe);
        wait_clk(10);
        vectors++;
        if (m[15:0] !== 16'h00A5) begin miscompares++; $display("FAIL read_cipo: got %h expected 00a5", m[15:0]); end
        vectors++;
        if (bus.regs_flat !== 40'hA5_00_00_00_00) begin miscompares++; $display("FAIL read_regs: got %0h expected a500000000", bus.regs_flat); end
        vectors++;
        if ((strobe_cycles - s0) !== 0 || (err_cycles - e0) !== 0) begin
            miscompares++; $display("FAIL read_side_effects: got strobes %0d errs %0d expected 0 0", strobe_cycles - s0, err_cycles - e0);
        end
    endtask

    task automatic test_frame_len();
        logic [31:0] m;
        logic oe;
        int e0, s0;
        e0 = err_cycles;
        s0 = strobe_cycles;
        spi_xfer(32'h84A, 12, 1'b1, m, oe);
        wait_clk(10);
        vectors++;
        if (err_cycles - e0 !== 1) begin miscompares++; $display("FAIL short_err_pulse: got %0d clk expected 1", err_cycles - e0); end
        vectors++;
        if (bus.err_count !== 8'd1) begin miscompares++; $display("FAIL short_errcnt: got %0d expected 1", bus.err_count); end
        spi_xfer(32'h1_8133, 17, 1'b1, m, oe);
        wait_clk(10);
        vectors++;
        if (bus.err_count !== 8'd2) begin miscompares++; $display("FAIL long_errcnt: got %0d expected 2", bus.err_count); end
        vectors++;
        if (bus.regs_flat !== 40'hA5_00_00_00_00 || strobe_cycles != s0) begin
            miscompares++; $display("FAIL len_regs: got %0h strobes %0d expected a500000000 0", bus.regs_flat, strobe_cycles - s0);
        end
    endtask

    task automatic test_bad_addr();
        logic [31:0] m;
        logic oe;
        int e0, s0;
        e0 = err_cycles;
        s0 = strobe_cycles;
        spi_xfer(32'h90FF, 16, 1'b1, m, oe);
        wait_clk(10);
        vectors++;
        if (bus.regs_flat !== 40'hA5_00_00_00_00) begin miscompares++; $display("FAIL badaddr_regs: got %0h expected a500000000", bus.regs_flat); end
        vectors++;
        if ((strobe_cycles - s0) !== 0 || (err_cycles - e0) !== 0 || bus.err_count !== 8'd2) begin
            miscompares++; $display("FAIL badaddr_flags: got strobes %0d errs %0d cnt %0d expected 0 0 2",
                                    strobe_cycles - s0, err_cycles - e0, bus.err_count);
        end
        spi_xfer(32'h1000, 16, 1'b1, m, oe);
        wait_clk(10);
        vectors++;
        if (m[15:0] !== 16'h0000) begin miscompares++; $display("FAIL badaddr_read: got %h expected 0000", m[15:0]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] m;
        logic oe;
        int s0;
        spi_xfer(32'h102, 9, 1'b0, m, oe);
        rst = 1'b1;
        wait_clk(2);
        bus.ncs = 1'b1;
        wait_clk(1);
        vectors++;
        if (bus.regs_flat !== 40'h0 || bus.err_count !== 8'h0) begin
            miscompares++; $display("FAIL midreset_state: got regs %0h cnt %0d expected 0 0", bus.regs_flat, bus.err_count);
        end
        vectors++;
        if ({bus.wr_strobe, bus.frame_err, bus.cipo, bus.cipo_oe} !== 9'h0) begin
            miscompares++; $display("FAIL midreset_ctl: got %0h expected 0", {bus.wr_strobe, bus.frame_err, bus.cipo, bus.cipo_oe});
        end
        rst = 1'b0;
        wait_clk(4);
        s0 = strobe_cycles;
        spi_xfer(32'h8133, 16, 1'b1, m, oe);
        wait_clk(10);
        vectors++;
        if (bus.regs_flat !== 40'h00_00_00_33_00) begin miscompares++; $display("FAIL postreset_write: got %0h expected 3300", bus.regs_flat); end
        vectors++;
        if (strobe_cycles - s0 !== 1 || bus.err_count !== 8'h0) begin
            miscompares++; $display("FAIL postreset_flags: got strobes %0d cnt %0d expected 1 0", strobe_cycles - s0, bus.err_count);
        end
    endtask

    task automatic test_saturate();
        logic [31:0] m;
        logic oe;
        int e0;
        e0 = err_cycles;
        for (int k = 0; k < 300; k++) begin
            spi_xfer(32'h1, 2, 1'b1, m, oe);
            wait_clk(4);
        end
        wait_clk(10);
        vectors++;
        if (bus.err_count !== 8'hFF) begin miscompares++; $display("FAIL sat_errcnt: got %0h expected ff", bus.err_count); end
        vectors++;
        if (err_cycles - e0 !== 300) begin miscompares++; $display("FAIL sat_pulses: got %0d expected 300", err_cycles - e0); end
        vectors++;
        if (bus.regs_flat !== 40'h00_00_00_33_00) begin miscompares++; $display("FAIL sat_regs: got %0h expected 3300", bus.regs_flat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] m;
        logic oe;
        int s0, e0;
        s0 = strobe_cycles;
        e0 = err_cycles;
        spi_xfer(32'h8011, 16, 1'b1, m, oe);
        wait_clk(1);
        spi_xfer(32'h8222, 16, 1'b1, m, oe);
        wait_clk(10);
        vectors++;
        if (bus.regs_flat !== 40'h00_00_22_33_11) begin miscompares++; $display("FAIL b2b_regs: got %0h expected 223311", bus.regs_flat); end
        vectors++;
        if (strobe_cycles - s0 !== 2 || err_cycles - e0 !== 0) begin
            miscompares++; $display("FAIL b2b_flags: got strobes %0d errs %0d expected 2 0", strobe_cycles - s0, err_cycles - e0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_frame_len();
        test_bad_addr();
        test_reset_mid();
        test_saturate();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
